// File: rtl/edsac_mem_pkg.sv
// Shared constants for the EDSAC mercury delay-line store.
//   EDSAC_WORD_BITS  : pulse positions per minor cycle (17 data bits + 1 gap)
//   EDSAC_TANK_WORDS : short words circulating in one tank
//   in_long_pair()   : long-word pairing rule; a long word occupies the
//                      even/odd slot pair sharing all address bits but bit 0
package edsac_mem_pkg;

    localparam int EDSAC_WORD_BITS       = 18;
    localparam int EDSAC_TANK_WORDS      = 32;
    localparam int EDSAC_LONG_PAIR_SHIFT = 1;

    function automatic logic in_long_pair(input int unsigned pos, input int unsigned addr);
        return (pos >> EDSAC_LONG_PAIR_SHIFT) == (addr >> EDSAC_LONG_PAIR_SHIFT);
    endfunction

endpackage

// File: rtl/delay_line.sv
// Shift store modelling the mercury column: DEPTH stages, one per clock.
// Ports:
//   r1_clk : pulse clock
//   r1_rst : synchronous active-high reset, clears every stage
//   d      : bit entering the line
//   q      : bit emerging from the last stage (combinational from the stage)
module delay_line #(
    parameter int DEPTH = 576
) (
    input  logic r1_clk,
    input  logic r1_rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge r1_clk) begin
        if (r1_rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/memory_delay_tank.sv
// One EDSAC memory tank: a recirculating delay line with pulse/minor-cycle
// timing, slot selection and write/clear/read gating.
// Ports:
//   r1_clk, r1_rst     : pulse clock, synchronous active-high reset
//   r1_mib             : serial input bit
//   r1_addr, r1_long   : selected slot (or slot pair in long mode)
//   r1_t_clr/in/out    : clear, write and read gates for the selected slot
//   r1_mob             : registered gated readout
//   monitor            : registered copy of every emerging bit
//   r1_bit_pos         : current pulse position within the minor cycle
//   r1_word_pos        : current minor cycle (slot) number
//   r1_sel             : current position lies in the selected slot
module memory_delay_tank
    import edsac_mem_pkg::*;
#(
    parameter int WORD_BITS = EDSAC_WORD_BITS,
    parameter int N_WORDS   = EDSAC_TANK_WORDS,
    parameter int ADDR_W    = $clog2(N_WORDS)
) (
    input  logic                         r1_clk,
    input  logic                         r1_rst,
    input  logic                         r1_mib,
    input  logic [ADDR_W-1:0]            r1_addr,
    input  logic                         r1_long,
    input  logic                         r1_t_clr,
    input  logic                         r1_t_in,
    input  logic                         r1_t_out,
    output logic                         r1_mob,
    output logic                         monitor,
    output logic [$clog2(WORD_BITS)-1:0] r1_bit_pos,
    output logic [ADDR_W-1:0]            r1_word_pos,
    output logic                         r1_sel
);

    localparam int BIT_W = $clog2(WORD_BITS);
    localparam int DEPTH = N_WORDS * WORD_BITS;

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_BITS - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);

    logic emerging;
    logic line_d;

    delay_line #(
        .DEPTH (DEPTH)
    ) u_line (
        .r1_clk (r1_clk),
        .r1_rst (r1_rst),
        .d      (line_d),
        .q      (emerging)
    );

    // Address and mode are used live, never registered, so a change is seen
    // at the very next pulse position.
    always_comb begin
        r1_sel = (r1_word_pos == r1_addr) ||
                 (r1_long && in_long_pair(32'(r1_word_pos), 32'(r1_addr)));
    end

    // Write beats clear; with neither gate active the emerging bit recirculates.
    always_comb begin
        line_d = emerging;
        if (r1_sel && r1_t_in) begin
            line_d = r1_mib;
        end else if (r1_sel && r1_t_clr) begin
            line_d = 1'b0;
        end
    end

    always_ff @(posedge r1_clk) begin
        if (r1_rst) begin
            r1_bit_pos  <= '0;
            r1_word_pos <= '0;
        end else if (r1_bit_pos == LAST_BIT) begin
            r1_bit_pos  <= '0;
            r1_word_pos <= (r1_word_pos == LAST_WORD) ? '0 : r1_word_pos + ADDR_W'(1);
        end else begin
            r1_bit_pos  <= r1_bit_pos + BIT_W'(1);
        end
    end

    always_ff @(posedge r1_clk) begin
        if (r1_rst) begin
            r1_mob  <= 1'b0;
            monitor <= 1'b0;
        end else begin
            r1_mob  <= emerging & r1_sel & r1_t_out;
            monitor <= emerging;
        end
    end

endmodule

// File: tb/tb_memory_delay_tank.sv
module tb_memory_delay_tank;

    localparam int WB    = 18;
    localparam int NW    = 32;
    localparam int DEPTH = WB * NW;

    logic       r1_clk = 1'b0;
    logic       r1_rst;
    logic       r1_mib;
    logic [4:0] r1_addr;
    logic       r1_long;
    logic       r1_t_clr;
    logic       r1_t_in;
    logic       r1_t_out;
    logic       r1_mob;
    logic       monitor;
    logic [4:0] r1_bit_pos;
    logic [4:0] r1_word_pos;
    logic       r1_sel;

    memory_delay_tank dut (
        .r1_clk      (r1_clk),
        .r1_rst      (r1_rst),
        .r1_mib      (r1_mib),
        .r1_addr     (r1_addr),
        .r1_long     (r1_long),
        .r1_t_clr    (r1_t_clr),
        .r1_t_in     (r1_t_in),
        .r1_t_out    (r1_t_out),
        .r1_mob      (r1_mob),
        .monitor     (monitor),
        .r1_bit_pos  (r1_bit_pos),
        .r1_word_pos (r1_word_pos),
        .r1_sel      (r1_sel)
    );

    always #5 r1_clk = ~r1_clk;

    int checks = 0;
    int errors = 0;

    // Reference: contents of the tank by (slot, bit position), plus the
    // position the tank is currently presenting.
    bit tank [0:NW-1][0:WB-1];
    int m_bit;
    int m_word;

    typedef struct {
        bit          lng;
        logic [4:0]  addr;
        bit          tin;
        bit          tclr;
        logic [17:0] data;
        logic [4:0]  rd_addr;
        logic [17:0] exp_word;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (word %0d bit %0d)", name, act, req, m_word, m_bit);
        end
    endtask

    task automatic clear_model();
        foreach (tank[w, b]) tank[w][b] = 1'b0;
        m_bit  = 0;
        m_word = 0;
    endtask

    // One pulse period: inputs were set by the caller; check the combinational
    // outputs before the edge, update the reference, check registered outputs after.
    task automatic cycle();
        bit em, s, nb, e_mob, e_mon;
        #1;
        s = (m_word == int'(r1_addr)) || (r1_long && (m_word / 2 == int'(r1_addr) / 2));
        check("r1_sel", 32'(r1_sel), 32'(s));
        check("r1_bit_pos", 32'(r1_bit_pos), m_bit);
        check("r1_word_pos", 32'(r1_word_pos), m_word);
        em = tank[m_word][m_bit];
        if (r1_rst) begin
            clear_model();
            e_mob = 1'b0;
            e_mon = 1'b0;
        end else begin
            e_mob = em & s & r1_t_out;
            e_mon = em;
            if (s && r1_t_in)       nb = r1_mib;
            else if (s && r1_t_clr) nb = 1'b0;
            else                    nb = em;
            tank[m_word][m_bit] = nb;
            if (m_bit == WB - 1) begin
                m_bit  = 0;
                m_word = (m_word + 1) % NW;
            end else begin
                m_bit++;
            end
        end
        @(posedge r1_clk);
        #1;
        check("r1_mob", 32'(r1_mob), 32'(e_mob));
        check("monitor", 32'(monitor), 32'(e_mon));
    endtask

    task automatic gates_low();
        r1_rst   = 1'b0;
        r1_mib   = 1'b0;
        r1_long  = 1'b0;
        r1_t_clr = 1'b0;
        r1_t_in  = 1'b0;
        r1_t_out = 1'b0;
    endtask

    // Full pass with t_out on one short slot; gathers what r1_mob shows.
    task automatic read_slot(input logic [4:0] slot, output logic [17:0] word);
        int w, b;
        word = '0;
        gates_low();
        r1_addr  = slot;
        r1_t_out = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            w = m_word;
            b = m_bit;
            cycle();
            if (w == int'(slot)) word[b] = r1_mob;
        end
        r1_t_out = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        logic [17:0] d;
        d = v.data;
        gates_low();
        r1_addr  = v.addr;
        r1_long  = v.lng;
        r1_t_in  = v.tin;
        r1_t_clr = v.tclr;
        for (int i = 0; i < DEPTH; i++) begin
            r1_mib = d[m_bit];
            cycle();
        end
        gates_low();
    endtask

    task automatic run_to(input int word, input int bitp);
        for (int i = 0; i < DEPTH && !(m_word == word && m_bit == bitp); i++) cycle();
        check("run_to_position", 32'(m_word * WB + m_bit), 32'(word * WB + bitp));
    endtask

    initial begin
        logic [17:0] rd;
        int ones;

        vecs[0] = '{1'b0, 5'd5, 1'b1, 1'b0, 18'h2AAAA, 5'd5, 18'h2AAAA};
        vecs[1] = '{1'b0, 5'd5, 1'b0, 1'b0, 18'h3FFFF, 5'd5, 18'h2AAAA};
        vecs[2] = '{1'b0, 5'd4, 1'b1, 1'b0, 18'h15555, 5'd4, 18'h15555};
        vecs[3] = '{1'b0, 5'd5, 1'b0, 1'b1, 18'h3FFFF, 5'd5, 18'h00000};
        vecs[4] = '{1'b0, 5'd5, 1'b0, 1'b0, 18'h00000, 5'd4, 18'h15555};
        vecs[5] = '{1'b1, 5'd7, 1'b1, 1'b0, 18'h3FFFF, 5'd6, 18'h3FFFF};
        vecs[6] = '{1'b0, 5'd0, 1'b0, 1'b0, 18'h00000, 5'd7, 18'h3FFFF};
        vecs[7] = '{1'b0, 5'd0, 1'b0, 1'b0, 18'h00000, 5'd8, 18'h00000};
        vecs[8] = '{1'b0, 5'd9, 1'b1, 1'b1, 18'h2F0F1, 5'd9, 18'h2F0F1};
        vecs[9] = '{1'b1, 5'd6, 1'b0, 1'b1, 18'h3FFFF, 5'd7, 18'h00000};

        gates_low();
        r1_addr = '0;
        r1_rst  = 1'b1;
        repeat (2) @(posedge r1_clk);
        #1;
        clear_model();
        check("reset_bit_pos", 32'(r1_bit_pos), 0);
        check("reset_word_pos", 32'(r1_word_pos), 0);
        check("reset_mob", 32'(r1_mob), 0);
        check("reset_monitor", 32'(monitor), 0);
        r1_rst = 1'b0;

        // Empty tank for one revolution; slot counter wraps on the last pulse.
        for (int i = 0; i < DEPTH - 1; i++) cycle();
        check("pre_wrap_word_pos", 32'(r1_word_pos), 31);
        check("pre_wrap_bit_pos", 32'(r1_bit_pos), 17);
        cycle();
        check("wrap_word_pos", 32'(r1_word_pos), 0);
        check("wrap_bit_pos", 32'(r1_bit_pos), 0);

        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            read_slot(vecs[i].rd_addr, rd);
            check($sformatf("vec%0d_read", i), 32'(rd), 32'(vecs[i].exp_word));
        end

        // Write gate raised at pulse 9 of slot 12 fills only pulses 9..17.
        gates_low();
        r1_addr = 5'd12;
        run_to(12, 9);
        r1_t_in = 1'b1;
        r1_mib  = 1'b1;
        while (m_word == 12) cycle();
        gates_low();
        read_slot(5'd12, rd);
        check("mid_slot_write", 32'(rd), 32'h3FE00);

        // Reset in the middle of a write to slot 10.
        gates_low();
        r1_addr = 5'd10;
        run_to(10, 0);
        r1_t_in = 1'b1;
        r1_mib  = 1'b1;
        while (m_bit != 7) cycle();
        r1_rst = 1'b1;
        cycle();
        check("rst_mob", 32'(r1_mob), 0);
        check("rst_monitor", 32'(monitor), 0);
        check("rst_bit_pos", 32'(r1_bit_pos), 0);
        check("rst_word_pos", 32'(r1_word_pos), 0);
        gates_low();
        ones = 0;
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            ones += int'(monitor);
        end
        check("post_reset_monitor_ones", 32'(ones), 0);
        read_slot(5'd10, rd);
        check("post_reset_slot10", 32'(rd), 0);

        // Random gating and live address changes against the reference.
        for (int i = 0; i < 3000; i++) begin
            r1_addr  = 5'($urandom_range(0, NW - 1));
            r1_long  = ($urandom_range(0, 3) == 0);
            r1_t_in  = ($urandom_range(0, 3) == 0);
            r1_t_clr = ($urandom_range(0, 3) == 0);
            r1_t_out = ($urandom_range(0, 1) == 0);
            r1_mib   = 1'($urandom_range(0, 1));
            cycle();
        end
        gates_low();
        r1_t_out = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            r1_addr = 5'($urandom_range(0, NW - 1));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_delay_tank.md
MEMORY_DELAY_TANK -- requirements
Module: memory_delay_tank

Interface
REQ-001 SHALL have parameter WORD_BITS, default 18, meaning pulse positions per minor cycle (17 data bits plus 1 gap).
REQ-002 SHALL have parameter N_WORDS, default 32, meaning short words circulating per tank; it SHALL be a power of two, at least 2.
REQ-003 SHALL have parameter ADDR_W, default $clog2(N_WORDS), meaning word-address width.
REQ-004 SHALL have port r1_clk, input, width 1: pulse clock; one bit position per cycle.
REQ-005 SHALL have port r1_rst, input, width 1: synchronous, active-high reset.
REQ-006 SHALL have port r1_mib, input, width 1: serial memory input bit.
REQ-007 SHALL have port r1_addr, input, width ADDR_W: selected short-word slot.
REQ-008 SHALL have port r1_long, input, width 1: long-word mode, selecting the slot pair {addr[ADDR_W-1:1],0/1}.
REQ-009 SHALL have port r1_t_clr, input, width 1: clear gate for the selected slot.
REQ-010 SHALL have port r1_t_in, input, width 1: write gate for the selected slot.
REQ-011 SHALL have port r1_t_out, input, width 1: read gate for the selected slot.
REQ-012 SHALL have port r1_mob, output, width 1: registered memory output bit.
REQ-013 SHALL have port monitor, output, width 1: registered copy of every emerging bit, for the CRT monitor.
REQ-014 SHALL have port r1_bit_pos, output, width $clog2(WORD_BITS): current pulse position.
REQ-015 SHALL have port r1_word_pos, output, width ADDR_W: current minor-cycle number.
REQ-016 SHALL have port r1_sel, output, width 1: the current position lies inside the selected slot.

Function
REQ-017 SHALL model the line as a DEPTH = N_WORDS*WORD_BITS stage shift register advancing one stage per r1_clk; the emerging bit is the last stage.
REQ-018 SHALL increment r1_bit_pos every cycle, wrapping WORD_BITS-1 to 0; on that wrap r1_word_pos SHALL increment, wrapping N_WORDS-1 to 0.
REQ-019 SHALL assert r1_sel (combinational) when r1_word_pos == r1_addr, or, with r1_long=1, when r1_word_pos[ADDR_W-1:1] == r1_addr[ADDR_W-1:1].
REQ-020 SHALL compute the re-entered bit as follows: r1_mib if r1_sel&r1_t_in; else 0 if r1_sel&r1_t_clr; else the emerging bit (recirculation).
REQ-021 Write SHALL have priority over clear when both gates are high in the same cycle.
REQ-022 Gates SHALL be sampled per cycle; a gate raised mid-slot SHALL affect only the remaining positions of that slot.
REQ-023 r1_mob SHALL equal, one cycle later, emerging_bit & r1_sel & r1_t_out; otherwise it SHALL be 0.
REQ-024 Readout SHALL be non-destructive; the emerging bit SHALL still recirculate unless a write or clear applies.
REQ-025 monitor SHALL equal the emerging bit, delayed one cycle, regardless of gates.
REQ-026 A bit written at position p SHALL re-emerge exactly DEPTH cycles later, at the same (r1_word_pos, r1_bit_pos).
REQ-027 Changes to r1_addr or r1_long SHALL take effect in the same cycle; the block SHALL NOT latch them.

Reset
REQ-028 While r1_rst=1 at a clock edge, all stages, r1_bit_pos, r1_word_pos, r1_mob and monitor SHALL become 0.
REQ-029 Reset SHALL override all gates, including a reset applied mid-slot or mid-write.
REQ-030 On the first cycle after reset, the position SHALL be (0,0).

Structure
REQ-031 A shared package edsac_mem_pkg SHALL hold EDSAC_WORD_BITS=18, EDSAC_TANK_WORDS=32 and the long-word pairing convention.
REQ-032 A sub-module delay_line (parameter DEPTH; ports r1_clk, r1_rst, d, q) SHALL implement the shift store.
REQ-033 The timing counters, slot select, gating and output registers SHALL reside in memory_delay_tank.

Verification
REQ-034 Reset, then run 576 cycles with all gates low -> monitor=0 throughout; r1_word_pos wraps 31->0 at cycle 576.
REQ-035 addr=5, t_in=1 for slot 5 with the pattern 18'h2AAAA, then t_out=1 on the next pass (576 cycles later) -> r1_mob reproduces 18'h2AAAA one cycle delayed, and again on the following pass.
REQ-036 After the REQ-035 write, t_clr=1 for slot 5 -> the next pass shows monitor=0 in slot 5, with slots 4 and 6 unchanged.
REQ-037 r1_long=1, addr=7, write 36 ones -> slots 6 and 7 read all ones and slot 8 reads 0.
REQ-038 t_in=1 and t_clr=1 together with r1_mib=1 -> the bit is stored as 1.
REQ-039 Assert r1_rst mid-write at slot 10 -> all outputs are 0 next cycle, positions are (0,0), and a full pass reads 0.
